// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - VGA sync timing measurement, lock FSM and visible-pixel capture
module vga_capture #(
   parameter int H_TOTAL     = 800,
   parameter int V_TOTAL     = 525,
   parameter int H_START     = 144,
   parameter int V_START     = 35,
   parameter int H_VISIBLE   = 640,
   parameter int V_VISIBLE   = 480,
   parameter int LOCK_FRAMES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        h_sync,
   input  logic        v_sync,
   input  logic [4:0]  red,
   input  logic [5:0]  green,
   input  logic [4:0]  blue,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic [15:0] pix_data,
   output logic        pix_valid,
   output logic        frame_start,
   output logic        locked,
   output logic [9:0]  h_meas,
   output logic [9:0]  v_meas,
   output logic        sync_err
);

   // Index counters saturate here; reaching it is itself a timing violation.
   localparam logic [9:0]  IDX_MAX   = 10'd1023;
   localparam logic [9:0]  H_TOTAL_L = 10'(H_TOTAL);
   localparam logic [9:0]  V_TOTAL_L = 10'(V_TOTAL);
   localparam logic [9:0]  H_START_L = 10'(H_START);
   localparam logic [9:0]  V_START_L = 10'(V_START);
   // Window bounds carry an extra bit so START+VISIBLE = 1024 still compares correctly.
   localparam logic [10:0] H_FIRST   = 11'(H_START);
   localparam logic [10:0] H_LAST    = 11'(H_START + H_VISIBLE);
   localparam logic [10:0] V_FIRST   = 11'(V_START);
   localparam logic [10:0] V_LAST    = 11'(V_START + V_VISIBLE);
   localparam int          CW        = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   // Input capture stage; the *_d copies exist only for edge detection.
   logic          hs_r;
   logic          hs_d;
   logic          vs_r;
   logic          vs_d;
   logic [15:0]   rgb_r;

   // Running position of the previous sample.
   logic [9:0]    h_cnt;
   logic [9:0]    v_idx;
   logic          v_pend;
   logic          h_seen;
   logic          v_seen;

   // Lock FSM.
   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] good_cnt;
   logic [CW-1:0] good_cnt_nxt;
   logic [CW-1:0] good_inc;
   logic          err_nxt;

   // Position and checks for the sample currently held in the capture stage.
   logic          h_lead;
   logic          v_lead;
   logic          line_zero;
   logic [9:0]    h_len;
   logic [9:0]    v_len;
   logic [9:0]    h_idx_cur;
   logic [9:0]    v_idx_cur;
   logic          h_bad;
   logic          v_bad;
   logic          h_sat;
   logic          v_sat;
   logic          violation;
   logic          h_vis;
   logic          v_vis;
   logic          pix_go;
   logic [9:0]    x_nxt;
   logic [9:0]    y_nxt;

   // Register every input once; nothing downstream sees the raw pins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hs_r  <= 1'b0;
         hs_d  <= 1'b0;
         vs_r  <= 1'b0;
         vs_d  <= 1'b0;
         rgb_r <= 16'd0;
      end else begin
         hs_r  <= h_sync;
         hs_d  <= hs_r;
         vs_r  <= v_sync;
         vs_d  <= vs_r;
         rgb_r <= {red, green, blue};
      end
   end

   // Leading (falling) edges of the active-low syncs, seen on the captured sample.
   assign h_lead    = hs_d & ~hs_r;
   assign v_lead    = vs_d & ~vs_r;
   // A vertical edge arms line 0; it takes effect on the same or next horizontal edge.
   assign line_zero = v_lead | v_pend;

   // Current sample position; lengths double as the saturating "next index".
   always_comb begin
      h_len     = (h_cnt == IDX_MAX) ? IDX_MAX : h_cnt + 10'd1;
      v_len     = (v_idx == IDX_MAX) ? IDX_MAX : v_idx + 10'd1;
      h_idx_cur = h_lead ? 10'd0 : h_len;
      v_idx_cur = v_idx;
      if (h_lead) begin
         v_idx_cur = line_zero ? 10'd0 : v_len;
      end
   end

   // Timing violations: wrong measured lengths, or an index hitting its ceiling.
   always_comb begin
      h_bad     = h_lead & h_seen & (h_len != H_TOTAL_L);
      v_bad     = v_lead & v_seen & (v_len != V_TOTAL_L);
      h_sat     = ~h_lead & (h_cnt == IDX_MAX - 10'd1);
      v_sat     = h_lead & ~line_zero & (v_idx == IDX_MAX - 10'd1);
      violation = h_bad | v_bad | h_sat | v_sat;
   end

   // Position counters and the pending-line-0 flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt  <= 10'd0;
         v_idx  <= 10'd0;
         v_pend <= 1'b0;
      end else begin
         h_cnt <= h_idx_cur;
         v_idx <= v_idx_cur;
         if (h_lead) begin
            v_pend <= 1'b0;
         end else if (v_lead) begin
            v_pend <= 1'b1;
         end
      end
   end

   // Measurements load on sync edges, skipping the first edge after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_meas <= 10'd0;
         v_meas <= 10'd0;
         h_seen <= 1'b0;
         v_seen <= 1'b0;
      end else begin
         if (h_lead) begin
            h_seen <= 1'b1;
            if (h_seen) begin
               h_meas <= h_len;
            end
         end
         if (v_lead) begin
            v_seen <= 1'b1;
            if (v_seen) begin
               v_meas <= v_len;
            end
         end
      end
   end

   // Lock FSM state and good-frame counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= SEARCH;
         good_cnt <= '0;
         sync_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         good_cnt <= good_cnt_nxt;
         sync_err <= err_nxt;
      end
   end

   assign good_inc = good_cnt + CW'(1);

   // Lock FSM next state; a violation always wins over a frame boundary.
   always_comb begin
      state_nxt    = state;
      good_cnt_nxt = good_cnt;
      err_nxt      = 1'b0;
      case (state)
         SEARCH: begin
            if (v_lead) begin
               state_nxt    = CHECK;
               good_cnt_nxt = '0;
            end
         end
         CHECK: begin
            if (violation) begin
               state_nxt = SEARCH;
               err_nxt   = 1'b1;
            end else if (v_lead) begin
               good_cnt_nxt = good_inc;
               if (good_inc == CW'(LOCK_FRAMES)) begin
                  state_nxt = LOCKED;
               end
            end
         end
         LOCKED: begin
            if (violation) begin
               state_nxt = SEARCH;
               err_nxt   = 1'b1;
            end
         end
         default: begin
            state_nxt    = SEARCH;
            good_cnt_nxt = '0;
         end
      endcase
   end

   assign locked = (state == LOCKED);

   // Visible-window decode for the captured sample.
   always_comb begin
      h_vis  = ({1'b0, h_idx_cur} >= H_FIRST) && ({1'b0, h_idx_cur} < H_LAST);
      v_vis  = ({1'b0, v_idx_cur} >= V_FIRST) && ({1'b0, v_idx_cur} < V_LAST);
      x_nxt  = h_idx_cur - H_START_L;
      y_nxt  = v_idx_cur - V_START_L;
      pix_go = h_vis & v_vis & (state == LOCKED) & ~violation;
   end

   // Pixel output stage; coordinates and data hold while no pixel is presented.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_x       <= 10'd0;
         pix_y       <= 10'd0;
         pix_data    <= 16'd0;
         pix_valid   <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         pix_valid   <= pix_go;
         frame_start <= pix_go & (x_nxt == 10'd0) & (y_nxt == 10'd0);
         if (pix_go) begin
            pix_x    <= x_nxt;
            pix_y    <= y_nxt;
            pix_data <= rgb_r;
         end
      end
   end

endmodule

// File: tb/tb_vga_capture.sv
// tb/tb_vga_capture.sv - scoreboard bench for vga_capture on a reduced 40x20 raster
module tb_vga_capture;

   localparam int HT   = 40;
   localparam int VT   = 20;
   localparam int HST  = 8;
   localparam int VST  = 3;
   localparam int HVIS = 24;
   localparam int VVIS = 12;
   localparam int HSW  = 4;
   localparam int VSW  = 2;

   logic        clk;
   logic        rst;
   logic        h_sync;
   logic        v_sync;
   logic [4:0]  red;
   logic [5:0]  green;
   logic [4:0]  blue;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic        frame_start;
   logic        locked;
   logic [9:0]  h_meas;
   logic [9:0]  v_meas;
   logic        sync_err;

   vga_capture #(
      .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HST), .V_START(VST),
      .H_VISIBLE(HVIS), .V_VISIBLE(VVIS), .LOCK_FRAMES(2)
   ) dut (
      .clk(clk), .rst(rst), .h_sync(h_sync), .v_sync(v_sync),
      .red(red), .green(green), .blue(blue),
      .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data), .pix_valid(pix_valid),
      .frame_start(frame_start), .locked(locked), .h_meas(h_meas), .v_meas(v_meas),
      .sync_err(sync_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int          x;
      int          y;
      logic [15:0] d;
      bit          fs;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   cyc;
   int   pass_cnt;
   int   tot_cnt;
   int   err_cnt;
   int   err_base;
   int   last_err_h;
   int   last_err_v;

   task automatic chk(input string name, input longint act, input longint exp);
      tot_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_pix_x"}, pix_x, 0);
      chk({tag, "_pix_y"}, pix_y, 0);
      chk({tag, "_pix_data"}, pix_data, 0);
      chk({tag, "_pix_valid"}, pix_valid, 0);
      chk({tag, "_frame_start"}, frame_start, 0);
      chk({tag, "_locked"}, locked, 0);
      chk({tag, "_h_meas"}, h_meas, 0);
      chk({tag, "_v_meas"}, v_meas, 0);
      chk({tag, "_sync_err"}, sync_err, 0);
   endtask

   function automatic logic [15:0] pix_fn(input int line, input int s);
      logic [15:0] v;
      if (line == VST && s == HST) v = 16'hF81F;
      else v = 16'(line * 131) ^ 16'(s * 37) ^ 16'h5A5A;
      return v;
   endfunction

   // Monitor: pops the scoreboard whenever the DUT presents a pixel.
   task automatic mon_step();
      exp_t e;
      while (sb.size() > 0 && sb[0].due < cyc) begin
         e = sb.pop_front();
         tot_cnt++;
         $display("FAIL pix_missing: pix_valid=0 at cycle %0d, expected 1 for x=%0d y=%0d", e.due, e.x, e.y);
      end
      if (pix_valid) begin
         if (sb.size() == 0) begin
            tot_cnt++;
            $display("FAIL pix_unexpected: pix_valid=1 x=%0d y=%0d at cycle %0d, expected 0", pix_x, pix_y, cyc);
         end else begin
            e = sb.pop_front();
            chk("pix_cycle", cyc, e.due);
            chk("pix_x", pix_x, e.x);
            chk("pix_y", pix_y, e.y);
            chk("pix_data", pix_data, e.d);
            chk("frame_start", frame_start, e.fs);
         end
      end else if (frame_start) begin
         tot_cnt++;
         $display("FAIL frame_start_idle: frame_start=1 with pix_valid=0 at cycle %0d, expected 0", cyc);
      end
      if (sync_err) begin
         err_cnt++;
         last_err_h = h_meas;
         last_err_v = v_meas;
      end
   endtask

   task automatic drive_sample(input logic hs, input logic vs, input logic [15:0] d,
                               input bit exp, input int x, input int y);
      exp_t e;
      @(negedge clk);
      h_sync = hs;
      v_sync = vs;
      red    = d[15:11];
      green  = d[10:5];
      blue   = d[4:0];
      if (exp) begin
         e.x   = x;
         e.y   = y;
         e.d   = d;
         e.fs  = (x == 0 && y == 0);
         e.due = cyc + 2;
         sb.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_sample(1'b1, 1'b1, 16'd0, 1'b0, 0, 0);
   endtask

   task automatic drive_line(input int line, input int len, input bit exp);
      for (int s = 0; s < len; s++) begin
         bit vis;
         vis = (line >= VST) && (line < VST + VVIS) && (s >= HST) && (s < HST + HVIS);
         drive_sample(s >= HSW, line >= VSW, pix_fn(line, s), exp && vis, s - HST, line - VST);
      end
   endtask

   task automatic drive_frame(input int n_lines, input int short_line, input int exp_lines);
      for (int l = 0; l < n_lines; l++)
         drive_line(l, (l == short_line) ? HT - 1 : HT, l < exp_lines);
   endtask

   initial begin
      rst = 1'b1; h_sync = 1'b1; v_sync = 1'b1; red = '0; green = '0; blue = '0;
      cyc = 0; pass_cnt = 0; tot_cnt = 0; err_cnt = 0; last_err_h = 0; last_err_v = 0;
      fork
         forever begin @(posedge clk); cyc++; end
         forever begin @(negedge clk); mon_step(); end
      join_none

      repeat (3) @(negedge clk);
      chk_zero("rst_init");
      rst = 1'b0;
      idle(5);
      err_base = err_cnt;

      // Acquire lock: sync frame, two good frames, pixels from the third.
      drive_frame(VT, -1, 0);
      drive_frame(VT, -1, 0);
      chk("acq_locked_before", locked, 0);
      drive_frame(VT, -1, VT);
      chk("acq_locked_after", locked, 1);
      chk("acq_h_meas", h_meas, HT);
      chk("acq_v_meas", v_meas, VT);
      chk("acq_no_sync_err", err_cnt - err_base, 0);

      // Short line while locked: error at the next edge, relock two frames later.
      err_base = err_cnt;
      drive_frame(VT, 5, 6);
      chk("short_sync_err_count", err_cnt - err_base, 1);
      chk("short_err_h_meas", last_err_h, HT - 1);
      chk("short_locked", locked, 0);
      drive_frame(VT, -1, 0);
      drive_frame(VT, -1, 0);
      chk("short_relock_before", locked, 0);
      drive_frame(VT, -1, VT);
      chk("short_relock_after", locked, 1);
      chk("short_no_extra_err", err_cnt - err_base, 1);

      // Horizontal saturation while locked.
      err_base = err_cnt;
      drive_line(VT, 1104, 1'b0);
      chk("sat_sync_err_count", err_cnt - err_base, 1);
      chk("sat_locked", locked, 0);

      // Short frame during CHECK; the error edge must not count as a CHECK entry.
      err_base = err_cnt;
      drive_frame(VT, -1, 0);
      drive_frame(VT - 1, -1, 0);
      drive_frame(VT, -1, 0);
      chk("vshort_sync_err_count", err_cnt - err_base, 1);
      chk("vshort_err_v_meas", last_err_v, VT - 1);
      chk("vshort_locked", locked, 0);
      drive_frame(VT, -1, 0);
      drive_frame(VT, -1, 0);
      chk("vshort_relock_before", locked, 0);
      drive_frame(VT, -1, VT);
      chk("vshort_relock_after", locked, 1);

      // Reset in the middle of a captured line.
      for (int l = 0; l < 9; l++) drive_line(l, HT, 1'b1);
      drive_line(9, 20, 1'b1);
      @(negedge clk);
      #2;
      rst = 1'b1; h_sync = 1'b1; v_sync = 1'b1;
      sb.delete();
      #1;
      chk_zero("rst_mid");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(5);
      chk("post_rst_h_meas", h_meas, 0);
      chk("post_rst_v_meas", v_meas, 0);
      drive_frame(VT, -1, 0);
      drive_frame(VT, -1, 0);
      chk("post_rst_locked_before", locked, 0);
      drive_frame(VT, -1, VT);
      chk("post_rst_locked_after", locked, 1);
      chk("post_rst_h_meas_final", h_meas, HT);
      chk("post_rst_v_meas_final", v_meas, VT);

      idle(4);
      chk("sb_drained", sb.size(), 0);
      chk("sync_err_total", err_cnt, 3);
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  H_TOTAL, 800, expected clk cycles per line
  V_TOTAL, 525, expected lines per frame
  H_START, 144, line sample index of first visible pixel (sync + back porch)
  V_START, 35, frame line index of first visible line
  H_VISIBLE, 640, visible pixels per line
  V_VISIBLE, 480, visible lines per frame
  LOCK_FRAMES, 2, consecutive good frames required to lock
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  pixel clock, sole clock
  rst  in  1  asynchronous, active-high reset
  h_sync  in  1  horizontal sync, active low
  v_sync  in  1  vertical sync, active low
  red  in  5  pixel red
  green  in  6  pixel green
  blue  in  5  pixel blue
  pix_x  out  10  visible column of pix_data
  pix_y  out  10  visible row of pix_data
  pix_data  out  16  {red, green, blue} of captured pixel
  pix_valid  out  1  pix_data/pix_x/pix_y valid this cycle
  frame_start  out  1  one-cycle pulse with pixel (0,0)
  locked  out  1  timing matches H_TOTAL/V_TOTAL
  h_meas  out  10  last measured line length, clk cycles
  v_meas  out  10  last measured frame length, lines
  sync_err  out  1  one-cycle pulse on timing violation while locked or checking

Function
REQ-003 All inputs SHALL be registered once before use; no input feeds an output combinationally.
REQ-004 Line sample index: the input sample on which h_sync first reads low SHALL be index 0; each later sample increments the index; saturate at 1023.
REQ-005 Frame line index: the line whose index-0 sample coincides with or first follows v_sync first reading low SHALL be line 0; each later h_sync leading edge increments the line index; saturate at 1023.
REQ-006 On each h_sync leading edge, h_meas SHALL load the prior line's sample count (last index + 1); it SHALL not load on the first edge after reset.
REQ-007 On each v_sync leading edge, v_meas SHALL load the prior frame's line count; it SHALL not load on the first edge after reset.
REQ-008 A sample is visible when H_START <= sample index < H_START+H_VISIBLE and V_START <= line index < V_START+V_VISIBLE.
REQ-009 For a visible sample while locked = 1, pix_valid SHALL be 1 exactly 2 clk after the sample is on the pins, with pix_x = sample index - H_START, pix_y = line index - V_START, pix_data = {red, green, blue}.
REQ-010 pix_valid SHALL be 0 for non-visible samples and whenever locked = 0; pix_x/pix_y/pix_data hold their last values when pix_valid = 0.
REQ-011 frame_start SHALL equal pix_valid AND pix_x = 0 AND pix_y = 0.
REQ-012 Lock FSM states: SEARCH, CHECK, LOCKED; locked = 1 only in LOCKED.
REQ-013 SEARCH -> CHECK on a v_sync leading edge; the good-frame count clears.
REQ-014 In CHECK and LOCKED, a frame is bad if any h_meas load != H_TOTAL, the v_meas load != V_TOTAL, or either index saturates.
REQ-015 CHECK: on each v_sync leading edge, a good completed frame increments the count; at count = LOCK_FRAMES go LOCKED; a bad frame goes SEARCH.
REQ-016 LOCKED -> SEARCH on the first violation (h_meas or v_meas mismatch, or saturation), detected at the edge or the saturation cycle; locked and pix_valid drop on the next clk.
REQ-017 sync_err SHALL pulse for one cycle on every violation detected in CHECK or LOCKED, and never in SEARCH.
REQ-018 When a v_sync leading edge and a violation occur in the same cycle, the violation takes priority: the FSM goes SEARCH, not CHECK.

Reset
REQ-019 While rst = 1: FSM = SEARCH, all counters and indices = 0, all outputs = 0, and the first-edge flags are re-armed.
REQ-020 rst asserted mid-frame SHALL abort capture immediately; after release, relock requires a full SEARCH -> CHECK -> LOCKED sequence.

Verification
REQ-021 Nominal 800x525 stream with 96-cycle h_sync and 2-line v_sync from reset -> locked = 1 after the 3rd v_sync leading edge (1 sync + 2 good frames); h_meas = 800, v_meas = 525.
REQ-022 Locked; drive line 35, sample 144 with RGB 16'hF81F -> 2 clk later pix_valid = 1, pix_x = 0, pix_y = 0, pix_data = 16'hF81F, frame_start = 1; the sample at index 783 gives pix_x = 639; sample 784 gives pix_valid = 0.
REQ-023 Locked; shorten one line to 799 cycles -> sync_err pulses once at the next h_sync edge, h_meas = 799, locked = 0, no pix_valid until 2 good frames after the next v_sync.
REQ-024 Locked; hold h_sync high for 1100 cycles -> saturation at index 1023, sync_err pulse, locked = 0.
REQ-025 Locked; assert rst at line 200 -> all outputs 0 within the reset cycle; after release and a nominal stream, relock timing matches REQ-021.
REQ-026 Frame of 524 lines during CHECK -> sync_err pulse, FSM returns to SEARCH, locked stays 0.
